// File: rtl/alu_pkg.sv
// ============================================================================
// alu_pkg : op-codes, FSM state encoding and default width for alu_seq
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

package alu_pkg;

  localparam int ALU_WIDTH_DEFAULT = 32;

  localparam logic [3:0] ALU_AND  = 4'b0000;
  localparam logic [3:0] ALU_OR   = 4'b0001;
  localparam logic [3:0] ALU_XOR  = 4'b0010;
  localparam logic [3:0] ALU_NOR  = 4'b0011;
  localparam logic [3:0] ALU_SLT  = 4'b0100;
  localparam logic [3:0] ALU_ADD  = 4'b0101;
  localparam logic [3:0] ALU_SUB  = 4'b0110;
  localparam logic [3:0] ALU_SLTU = 4'b0111;
  localparam logic [3:0] ALU_SLL  = 4'b1000;
  localparam logic [3:0] ALU_SRL  = 4'b1001;
  localparam logic [3:0] ALU_SRA  = 4'b1010;
  localparam logic [3:0] ALU_MUL  = 4'b1011;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  function automatic logic is_shift(input logic [3:0] op);
    return (op == ALU_SLL) || (op == ALU_SRL) || (op == ALU_SRA);
  endfunction

endpackage

`default_nettype wire

// File: rtl/alu_seq_comb.sv
// ============================================================================
// alu_seq_comb : single-cycle ALU ops (logic, ADD/SUB with overflow, SLT/SLTU)
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

module alu_seq_comb
  import alu_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH_DEFAULT
) (
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic [3:0]       i_op,
  output logic [WIDTH-1:0] o_result,
  output logic             o_overflow
);

  logic [WIDTH-1:0] w_bp;
  logic [WIDTH-1:0] w_sum;

  always_comb begin
    w_bp       = (i_op == ALU_SUB) ? (~i_b + WIDTH'(1)) : i_b;
    w_sum      = i_a + w_bp;
    o_result   = '0;
    o_overflow = 1'b0;
    case (i_op)
      ALU_AND:  o_result = i_a & i_b;
      ALU_OR:   o_result = i_a | i_b;
      ALU_XOR:  o_result = i_a ^ i_b;
      ALU_NOR:  o_result = ~(i_a | i_b);
      ALU_SLT:  o_result = {{(WIDTH-1){1'b0}}, ($signed(i_a) < $signed(i_b))};
      ALU_SLTU: o_result = {{(WIDTH-1){1'b0}}, (i_a < i_b)};
      ALU_ADD, ALU_SUB: begin
        o_result   = w_sum;
        // Overflow: operands agree in sign but the sum does not.
        o_overflow = (i_a[WIDTH-1] == w_bp[WIDTH-1]) && (w_sum[WIDTH-1] != i_a[WIDTH-1]);
      end
      default: o_result = '0;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/alu_seq.sv
// ============================================================================
// alu_seq : multi-cycle ALU with valid/ready handshake, bit-serial shifts
//           and optional shift-add multiplier (enabled by ALU_SEQ_MUL_EN)
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

module alu_seq
  import alu_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       alu_op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             overflow,
  output logic             illegal
);

  localparam int SHW = $clog2(WIDTH);
  localparam int CW  = SHW + 1;

  state_t           r_state;
  logic [3:0]       r_op;
  logic [WIDTH-1:0] r_work;
  logic [CW-1:0]    r_cnt;
  logic             r_in_ready;
  logic             r_out_valid;
  logic [WIDTH-1:0] r_result;
  logic             r_zero;
  logic             r_overflow;
  logic             r_illegal;

  logic [WIDTH-1:0] w_comb_res;
  logic             w_comb_ovf;
  logic             w_is_mul;
  logic             w_is_illegal;
  logic [WIDTH-1:0] w_shift_next;
  logic [WIDTH-1:0] w_work_next;
  logic [WIDTH-1:0] w_iter_res;

  alu_seq_comb #(.WIDTH(WIDTH)) u_comb (
    .i_a        (a),
    .i_b        (b),
    .i_op       (alu_op),
    .o_result   (w_comb_res),
    .o_overflow (w_comb_ovf)
  );

`ifdef ALU_SEQ_MUL_EN
  logic [WIDTH-1:0] r_mplr;
  logic [WIDTH-1:0] r_acc;
  logic [WIDTH-1:0] w_acc_next;
  assign w_is_mul     = (alu_op == ALU_MUL);
  assign w_is_illegal = (alu_op > ALU_MUL);
  assign w_acc_next   = r_acc + (r_mplr[0] ? r_work : '0);
`else
  assign w_is_mul     = 1'b0;
  assign w_is_illegal = (alu_op >= ALU_MUL);
`endif

  always_comb begin
    case (r_op)
      ALU_SLL: w_shift_next = {r_work[WIDTH-2:0], 1'b0};
      ALU_SRL: w_shift_next = {1'b0, r_work[WIDTH-1:1]};
      default: w_shift_next = {r_work[WIDTH-1], r_work[WIDTH-1:1]};
    endcase
    w_work_next = w_shift_next;
    w_iter_res  = w_shift_next;
`ifdef ALU_SEQ_MUL_EN
    // The multiplicand rides in r_work, shifting left once per iteration.
    if (r_op == ALU_MUL) begin
      w_work_next = {r_work[WIDTH-2:0], 1'b0};
      w_iter_res  = w_acc_next;
    end
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_op        <= '0;
      r_work      <= '0;
      r_cnt       <= '0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_result    <= '0;
      r_zero      <= 1'b0;
      r_overflow  <= 1'b0;
      r_illegal   <= 1'b0;
`ifdef ALU_SEQ_MUL_EN
      r_mplr      <= '0;
      r_acc       <= '0;
`endif
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (in_valid && r_in_ready) begin
            r_op       <= alu_op;
            r_work     <= a;
            r_in_ready <= 1'b0;
            r_overflow <= 1'b0;
            r_illegal  <= 1'b0;
            if (w_is_illegal) begin
              r_state     <= ST_DONE;
              r_out_valid <= 1'b1;
              r_result    <= '0;
              r_zero      <= 1'b1;
              r_illegal   <= 1'b1;
            end else if (is_shift(alu_op)) begin
              if (b[SHW-1:0] == '0) begin
                r_state     <= ST_DONE;
                r_out_valid <= 1'b1;
                r_result    <= a;
                r_zero      <= (a == '0);
              end else begin
                r_state <= ST_BUSY;
                r_cnt   <= {1'b0, b[SHW-1:0]};
              end
            end else if (w_is_mul) begin
              r_state <= ST_BUSY;
              r_cnt   <= CW'(WIDTH);
`ifdef ALU_SEQ_MUL_EN
              r_mplr  <= b;
              r_acc   <= '0;
`endif
            end else begin
              r_state     <= ST_DONE;
              r_out_valid <= 1'b1;
              r_result    <= w_comb_res;
              r_zero      <= (w_comb_res == '0);
              r_overflow  <= w_comb_ovf;
            end
          end
        end
        ST_BUSY: begin
          r_work <= w_work_next;
`ifdef ALU_SEQ_MUL_EN
          r_mplr <= {1'b0, r_mplr[WIDTH-1:1]};
          r_acc  <= w_acc_next;
`endif
          if (r_cnt == CW'(1)) begin
            r_state     <= ST_DONE;
            r_out_valid <= 1'b1;
            r_result    <= w_iter_res;
            r_zero      <= (w_iter_res == '0);
          end else begin
            r_cnt <= r_cnt - CW'(1);
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            r_state     <= ST_IDLE;
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
          end
        end
        default: begin
          r_state     <= ST_IDLE;
          r_out_valid <= 1'b0;
          r_in_ready  <= 1'b1;
        end
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign result    = r_result;
  assign zero      = r_zero;
  assign overflow  = r_overflow;
  assign illegal   = r_illegal;

endmodule

`default_nettype wire

// File: tb/tb_alu_seq.sv
// ============================================================================
// tb_alu_seq : directed vector table plus handshake/reset corner sequences
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

module tb_alu_seq;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic [3:0]   alu_op = '0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] result;
  logic         zero;
  logic         overflow;
  logic         illegal;

  int n_cmp  = 0;
  int n_fail = 0;

  alu_seq #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .alu_op    (alu_op),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .zero      (zero),
    .overflow  (overflow),
    .illegal   (illegal)
  );

  always #5 clk = ~clk;

  typedef struct {
    string      name;
    logic [3:0] op;
    logic [W-1:0] va;
    logic [W-1:0] vb;
    logic [W-1:0] res;
    logic       z;
    logic       ov;
    logic       il;
    int         lat;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic add(input string nm, input logic [3:0] op, input logic [W-1:0] va,
                     input logic [W-1:0] vb, input logic [W-1:0] res, input logic z,
                     input logic ov, input logic il, input int lat);
    vec_t v;
    v.name = nm; v.op = op; v.va = va; v.vb = vb; v.res = res;
    v.z = z; v.ov = ov; v.il = il; v.lat = lat;
    vecs.push_back(v);
  endtask

  // Issue one op, count edges to out_valid, then leave the result ready to drain.
  task automatic issue(input logic [3:0] op, input logic [W-1:0] va, input logic [W-1:0] vb,
                       output int lat);
    @(negedge clk);
    alu_op = op; a = va; b = vb; in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 100) begin
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  task automatic drain(input string nm);
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    chk({nm, ".out_valid_drop"}, W'(out_valid), W'(0));
    chk({nm, ".in_ready_back"}, W'(in_ready), W'(1));
  endtask

  initial begin
    int lat;
    logic [W-1:0] held;

    add("and",      4'b0000, 32'hF0F000FF, 32'h0FF0FF0F, 32'h00F0000F, 0, 0, 0, 1);
    add("or",       4'b0001, 32'h000000F0, 32'h0000000F, 32'h000000FF, 0, 0, 0, 1);
    add("xor",      4'b0010, 32'hFFFF0000, 32'hFF00FF00, 32'h00FFFF00, 0, 0, 0, 1);
    add("nor0",     4'b0011, 32'h00000000, 32'h00000000, 32'hFFFFFFFF, 0, 0, 0, 1);
    add("nor1",     4'b0011, 32'hFFFFFFFF, 32'h00000000, 32'h00000000, 1, 0, 0, 1);
    add("sub_eq",   4'b0110, 32'd15,       32'd15,       32'h00000000, 1, 0, 0, 1);
    add("sub_neg",  4'b0110, 32'd15,       32'd22,       32'hFFFFFFF9, 0, 0, 0, 1);
    add("sub_ovf",  4'b0110, 32'h80000000, 32'd1,        32'h7FFFFFFF, 0, 1, 0, 1);
    add("add_ovf",  4'b0101, 32'h7FFFFFFF, 32'd1,        32'h80000000, 0, 1, 0, 1);
    add("add_wrap", 4'b0101, 32'hFFFFFFFF, 32'd1,        32'h00000000, 1, 0, 0, 1);
    add("slt",      4'b0100, 32'hFFFFFFFF, 32'd1,        32'h00000001, 0, 0, 0, 1);
    add("sltu0",    4'b0111, 32'hFFFFFFFF, 32'd1,        32'h00000000, 1, 0, 0, 1);
    add("sltu1",    4'b0111, 32'd1,        32'hFFFFFFFF, 32'h00000001, 0, 0, 0, 1);
    add("ill_e",    4'b1110, 32'h12345678, 32'h9ABCDEF0, 32'h00000000, 1, 0, 1, 1);
    add("ill_f",    4'b1111, 32'h1,        32'h1,        32'h00000000, 1, 0, 1, 1);
    add("sra4",     4'b1010, 32'h80000000, 32'd4,        32'hF8000000, 0, 0, 0, 5);
    add("sra_pos",  4'b1010, 32'h7FFFFFF0, 32'd4,        32'h07FFFFFF, 0, 0, 0, 5);
    add("sll0",     4'b1000, 32'd1,        32'd0,        32'h00000001, 0, 0, 0, 1);
    add("sll31",    4'b1000, 32'd1,        32'd31,       32'h80000000, 0, 0, 0, 32);
    add("srl31",    4'b1001, 32'h80000000, 32'd31,       32'h00000001, 0, 0, 0, 32);
    add("srl_zero", 4'b1001, 32'd1,        32'd1,        32'h00000000, 1, 0, 0, 2);
    add("sll_hib",  4'b1000, 32'd3,        32'h00000021, 32'h00000006, 0, 0, 0, 2);
`ifdef ALU_SEQ_MUL_EN
    add("mul",      4'b1011, 32'd15,       32'd12,       32'd180,      0, 0, 0, 33);
    add("mul_neg",  4'b1011, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 0, 0, 0, 33);
`else
    add("mul_ill",  4'b1011, 32'd15,       32'd12,       32'h00000000, 1, 0, 1, 1);
`endif

    repeat (3) @(posedge clk);
    #1;
    chk("rst.in_ready",  W'(in_ready),  W'(1));
    chk("rst.out_valid", W'(out_valid), W'(0));
    chk("rst.result",    result,        W'(0));
    chk("rst.flags",     W'({zero, overflow, illegal}), W'(0));
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      issue(vecs[i].op, vecs[i].va, vecs[i].vb, lat);
      chk({vecs[i].name, ".lat"},      W'(lat),      W'(vecs[i].lat));
      chk({vecs[i].name, ".result"},   result,       vecs[i].res);
      chk({vecs[i].name, ".zero"},     W'(zero),     W'(vecs[i].z));
      chk({vecs[i].name, ".overflow"}, W'(overflow), W'(vecs[i].ov));
      chk({vecs[i].name, ".illegal"},  W'(illegal),  W'(vecs[i].il));
      drain(vecs[i].name);
    end

    // Back-pressure: result holds for 10 cycles while a competing request is ignored.
    issue(4'b0101, 32'h7FFFFFFF, 32'd1, lat);
    held = result;
    chk("stall.result0", held, 32'h80000000);
    @(negedge clk);
    in_valid = 1'b1; alu_op = 4'b0000; a = '0; b = '0;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk);
      #1;
      chk("stall.result",    result,         32'h80000000);
      chk("stall.flags",     W'({out_valid, zero, overflow, illegal}), W'(4'b1010));
      chk("stall.in_ready",  W'(in_ready),   W'(0));
    end
    @(negedge clk);
    in_valid = 1'b0;
    drain("stall");

    // Asynchronous reset in the middle of a long shift aborts it.
    @(negedge clk);
    alu_op = 4'b1000; a = 32'd1; b = 32'd31; in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #2;
    chk("abort.busy", W'(in_ready), W'(0));
    rst_n = 1'b0;
    #1;
    chk("abort.out_valid", W'(out_valid), W'(0));
    chk("abort.in_ready",  W'(in_ready),  W'(1));
    chk("abort.result",    result,        W'(0));
    @(negedge clk);
    rst_n = 1'b1;
    repeat (40) begin
      @(posedge clk);
      #1;
      chk("abort.no_late_valid", W'(out_valid), W'(0));
    end

    issue(4'b0010, 32'hA5A5A5A5, 32'hA5A5A5A5, lat);
    chk("post.lat",    W'(lat),  W'(1));
    chk("post.result", result,   W'(0));
    chk("post.zero",   W'(zero), W'(1));
    drain("post");

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
